// File: rtl/axi_sram_slave_pkg.sv
// Shared types and constants for the AXI3 SRAM slave: FSM state encodings,
// AXI response/burst codes and the byte-lane merge used by the memory bank.
package axi_sram_slave_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 channel bundle between the CPU bridge (master) and the SRAM slave.
interface axi_sram_slave_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

endinterface

// File: rtl/axi_sram_slave_sram_bank.sv
// Word-addressed 32-bit storage: asynchronous read port, byte-enabled
// synchronous write port. Contents are deliberately not reset.
module sram_bank
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [3:0]        wstrb_i,
    input  logic [31:0]       wdata_i
);

    logic [31:0] mem_q [2**ADDR_W];

    assign rdata_o = mem_q[raddr_i];

    // Byte-lane write; a read of the same word in this cycle still sees old data.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= byte_merge(mem_q[waddr_i], wdata_i, wstrb_i);
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave memory: independent read and write FSMs in front of one SRAM bank.
// One outstanding transaction per direction, INCR bursts only, 4-byte beats.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read request
// R_WAIT | counting out the programmed read latency
// R_DATA | presenting a read beat, rlast on the final one
// W_IDLE | awready high, waiting for a write request
// W_DATA | wready high, committing beats until the burst count runs out
// W_RESP | bvalid high until the master takes the response
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 16,
    parameter int RD_DELAY       = 2
) (
    input  logic            aclk,
    input  logic            reset,
    axi_sram_slave_if.slave axi
);

    localparam int IW = MEM_WORDS_LOG2;
    localparam int DW = (RD_DELAY > 1) ? $clog2(RD_DELAY) : 1;
    localparam logic [DW-1:0] DLY_INIT = DW'((RD_DELAY > 0) ? RD_DELAY - 1 : 0);

    rd_state_e         r_state_q, r_state_d;
    logic [3:0]        r_id_q, r_id_d;
    logic [IW-1:0]     r_idx_q, r_idx_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic [DW-1:0]     r_dly_q, r_dly_d;
    logic [31:0]       r_data_q, r_data_d;
    logic              arready_c;

    wr_state_e         w_state_q, w_state_d;
    logic [3:0]        w_id_q, w_id_d;
    logic [IW-1:0]     w_idx_q, w_idx_d;
    logic [7:0]        w_cnt_q, w_cnt_d;
    logic              awready_c, wready_c;

    logic [31:0]       bank_rdata;
    logic              bank_we;

    sram_bank #(.ADDR_W(IW)) u_bank (
        .clk_i   (aclk),
        .raddr_i (r_idx_d),
        .rdata_o (bank_rdata),
        .we_i    (bank_we),
        .waddr_i (w_idx_q),
        .wstrb_i (axi.wstrb),
        .wdata_i (axi.wdata)
    );

    assign arready_c = (r_state_q == R_IDLE) && !reset;
    assign awready_c = (w_state_q == W_IDLE) && !reset;
    assign wready_c  = (w_state_q == W_DATA) && !reset;

    // Read FSM next-state: accept AR, wait out the latency, walk the burst.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        r_dly_d   = r_dly_q;
        case (r_state_q)
            R_IDLE: begin
                if (axi.arvalid && arready_c) begin
                    r_id_d    = axi.arid;
                    r_idx_d   = axi.araddr[IW+1:2];
                    r_cnt_d   = axi.arlen;
                    r_dly_d   = DLY_INIT;
                    r_state_d = (RD_DELAY > 0) ? R_WAIT : R_DATA;
                end
            end
            R_WAIT: begin
                if (r_dly_q == '0) r_state_d = R_DATA;
                else               r_dly_d   = r_dly_q - 1'b1;
            end
            R_DATA: begin
                if (axi.rready) begin
                    if (r_cnt_q == 8'd0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_idx_q + 1'b1;
                        r_cnt_d = r_cnt_q - 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Capture the next beat's word when a beat is about to be presented, so the
    // payload stays frozen through rready stalls.
    always_comb begin
        r_data_d = r_data_q;
        if ((r_state_d == R_DATA) && ((r_state_q != R_DATA) || axi.rready)) begin
            r_data_d = bank_rdata;
        end
    end

    // Read FSM state and payload registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_dly_q   <= '0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            r_dly_q   <= r_dly_d;
            r_data_q  <= r_data_d;
        end
    end

    // Write FSM next-state: accept AW, commit beats by count (wlast not trusted), respond.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        bank_we   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (axi.awvalid && awready_c) begin
                    w_id_d    = axi.awid;
                    w_idx_d   = axi.awaddr[IW+1:2];
                    w_cnt_d   = axi.awlen;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi.wvalid && wready_c) begin
                    bank_we = 1'b1;
                    w_idx_d = w_idx_q + 1'b1;
                    w_cnt_d = w_cnt_q - 8'd1;
                    if (w_cnt_q == 8'd0) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM state registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
        end
    end

    assign axi.arready = arready_c;
    assign axi.rvalid  = (r_state_q == R_DATA);
    assign axi.rlast   = (r_state_q == R_DATA) && (r_cnt_q == 8'd0);
    assign axi.rid     = r_id_q;
    assign axi.rdata   = r_data_q;
    assign axi.rresp   = AXI_RESP_OKAY;

    assign axi.awready = awready_c;
    assign axi.wready  = wready_c;
    assign axi.bvalid  = (w_state_q == W_RESP);
    assign axi.bid     = w_id_q;
    assign axi.bresp   = AXI_RESP_OKAY;

    // Request attributes that do not affect behaviour.
    logic unused_ok;
    assign unused_ok = ^{axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot,
                         axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot,
                         axi.wid, axi.wlast, axi.araddr[31:IW+2], axi.araddr[1:0],
                         axi.awaddr[31:IW+2], axi.awaddr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: drivers push expected beats/responses
// from a plain word-array model; monitors pop and compare on each handshake.
module tb_axi_sram_slave;
    import axi_sram_slave_pkg::*;

    localparam int LOG2 = 8;
    localparam int NW   = 256;
    localparam int RDD  = 2;

    logic aclk = 1'b0;
    logic reset = 1'b1;
    always #5 aclk = ~aclk;

    axi_sram_slave_if bus();

    axi_sram_slave #(.MEM_WORDS_LOG2(LOG2), .RD_DELAY(RDD)) dut (
        .aclk  (aclk),
        .reset (reset),
        .axi   (bus)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } rbeat_t;

    rbeat_t      rd_q[$];
    logic [3:0]  b_q[$];
    logic [31:0] model[NW];
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int rready_mode = 0;
    int bready_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mk_addr(input int word);
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_FC00) | (32'(word % NW) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        bus.rready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            if (rready_mode == 0)      bus.rready = 1'b1;
            else if (rready_mode == 1) bus.rready = ~bus.rready;
            else                       bus.rready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        bus.bready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            bus.bready = (bready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // R monitor: payload stability under stall, arready behaviour, scoreboard pop.
    initial begin
        logic pv, pr, pl, after_last;
        logic [31:0] pd;
        logic [3:0] pid;
        rbeat_t e;
        pv = 0; pr = 0; pl = 0; pd = '0; pid = '0; after_last = 0;
        forever begin
            @(negedge aclk);
            if (reset) begin
                pv = 0; after_last = 0;
            end else begin
                if (pv && !pr) begin
                    chk("r_hold_valid", 32'(bus.rvalid), 32'd1);
                    chk("r_hold_data", bus.rdata, pd);
                    chk("r_hold_id", 32'(bus.rid), 32'(pid));
                    chk("r_hold_last", 32'(bus.rlast), 32'(pl));
                end
                if (after_last) chk("arready_after_rlast", 32'(bus.arready), 32'd1);
                after_last = 0;
                if (bus.rvalid) chk("arready_busy", 32'(bus.arready), 32'd0);
                if (bus.rvalid && bus.rready) begin
                    if (rd_q.size() == 0) begin
                        fail_now("r_unexpected_beat");
                    end else begin
                        e = rd_q.pop_front();
                        chk("rid", 32'(bus.rid), 32'(e.id));
                        chk("rdata", bus.rdata, e.data);
                        chk("rlast", 32'(bus.rlast), 32'(e.last));
                        chk("rresp", 32'(bus.rresp), 32'd0);
                    end
                    after_last = bus.rlast;
                end
                pv = bus.rvalid; pr = bus.rready; pd = bus.rdata; pid = bus.rid; pl = bus.rlast;
            end
        end
    end

    // B monitor: response id/code and awready behaviour around the response.
    initial begin
        logic b_after;
        logic [3:0] e;
        b_after = 0;
        forever begin
            @(negedge aclk);
            if (reset) begin
                b_after = 0;
            end else begin
                if (b_after) chk("awready_after_b", 32'(bus.awready), 32'd1);
                b_after = 0;
                if (bus.bvalid) chk("awready_busy", 32'(bus.awready), 32'd0);
                if (bus.bvalid && bus.bready) begin
                    if (b_q.size() == 0) begin
                        fail_now("b_unexpected");
                    end else begin
                        e = b_q.pop_front();
                        chk("bid", 32'(bus.bid), 32'(e));
                        chk("bresp", 32'(bus.bresp), 32'd0);
                    end
                    b_after = 1;
                end
            end
        end
    end

    task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        bit ok;
        int idx;
        rbeat_t e;
        ok = 0;
        @(posedge aclk); #1;
        bus.araddr = addr; bus.arlen = len; bus.arid = id; bus.arsize = 3'b010;
        bus.arburst = 2'($urandom_range(0, 3)); bus.arvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge aclk);
            if (bus.arready) begin ok = 1; break; end
        end
        if (!ok) begin
            fail_now("ar_handshake_timeout");
        end else begin
            idx = int'(addr[LOG2+1:2]);
            for (int b = 0; b <= int'(len); b++) begin
                e.id = id; e.data = model[(idx + b) % NW]; e.last = (b == int'(len));
                rd_q.push_back(e);
            end
        end
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
    endtask

    // Burst write using wd_q/ws_q; abort_at >= 0 stops before that beat.
    task automatic wr_issue(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input int abort_at, input int max_gap);
        bit ok;
        int idx;
        ok = 0;
        @(posedge aclk); #1;
        bus.awaddr = addr; bus.awlen = len; bus.awid = id; bus.awsize = 3'b010;
        bus.awburst = AXI_BURST_INCR; bus.awvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge aclk);
            if (bus.awready) begin ok = 1; break; end
        end
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        if (!ok) begin
            fail_now("aw_handshake_timeout");
            return;
        end
        idx = int'(addr[LOG2+1:2]);
        for (int b = 0; b <= int'(len); b++) begin
            if (b == abort_at) break;
            bus.wdata = wd_q[b]; bus.wstrb = ws_q[b]; bus.wid = 4'($urandom);
            bus.wlast = (b == int'(len)); bus.wvalid = 1'b1;
            ok = 0;
            for (int t = 0; t < 200; t++) begin
                @(negedge aclk);
                if (b == 0 && t == 0) chk("wready_after_aw", 32'(bus.wready), 32'd1);
                if (bus.wready) begin ok = 1; break; end
            end
            if (!ok) begin
                fail_now("w_handshake_timeout");
                bus.wvalid = 1'b0;
                return;
            end
            model[(idx + b) % NW] = merge(model[(idx + b) % NW], wd_q[b], ws_q[b]);
            if (b == int'(len)) b_q.push_back(id);
            @(posedge aclk); #1;
            bus.wvalid = 1'b0;
            if (b == int'(len)) begin
                @(negedge aclk);
                chk("bvalid_after_wlast", 32'(bus.bvalid), 32'd1);
            end else begin
                repeat ($urandom_range(0, max_gap)) begin @(posedge aclk); #1; end
            end
        end
    endtask

    task automatic fill(input int n, input bit rnd_strb);
        wd_q.delete(); ws_q.delete();
        for (int i = 0; i < n; i++) begin
            wd_q.push_back($urandom);
            ws_q.push_back(rnd_strb ? 4'($urandom) : 4'hF);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge aclk);
            if (rd_q.size() == 0 && b_q.size() == 0 && !bus.rvalid && !bus.bvalid) begin
                ok = 1; break;
            end
        end
        if (!ok) fail_now("idle_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] oldv, newv;
        int wb, rb, op;
        logic [7:0] wl, rl;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'b010; bus.arburst = 2'b01;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'b010; bus.awburst = 2'b01;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;

        reset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rlast", 32'(bus.rlast), 32'd0);
        chk("rst_rid", 32'(bus.rid), 32'd0);
        chk("rst_bid", 32'(bus.bid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        @(posedge aclk); #1;
        reset = 1'b0;
        @(negedge aclk);
        chk("post_rst_arready", 32'(bus.arready), 32'd1);
        chk("post_rst_awready", 32'(bus.awready), 32'd1);

        for (int k = 0; k < NW / 16; k++) begin
            fill(16, 0);
            wr_issue(32'(k * 64), 8'd15, 4'(k), -1, 0);
        end
        wait_idle();

        wd_q = '{32'hDEADBEEF}; ws_q = '{4'hF};
        wr_issue(32'h40, 8'd0, 4'd0, -1, 0);
        wait_idle();
        ar_issue(32'h40, 8'd0, 4'd0);
        @(negedge aclk); chk("rvalid_T+1", 32'(bus.rvalid), 32'd0);
        @(negedge aclk); chk("rvalid_T+2", 32'(bus.rvalid), 32'd0);
        @(negedge aclk); chk("rvalid_T+3", 32'(bus.rvalid), 32'd1);
        wait_idle();

        wd_q = '{32'd1, 32'd2, 32'd3, 32'd4}; ws_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        wr_issue(32'h100, 8'd3, 4'd1, -1, 0);
        wait_idle();
        ar_issue(32'h100, 8'd3, 4'd5);
        wait_idle();

        wd_q = '{32'h11223344}; ws_q = '{4'hF};
        wr_issue(32'hC0, 8'd0, 4'd2, -1, 0);
        wd_q = '{32'hAABBCCDD}; ws_q = '{4'b0010};
        wr_issue(32'hC0, 8'd0, 4'd3, -1, 0);
        wait_idle();
        ar_issue(32'hC0, 8'd0, 4'd4);
        wait_idle();

        rready_mode = 1;
        ar_issue(32'h100, 8'd3, 4'd2);
        wait_idle();
        rready_mode = 0;

        fill(2, 0);
        fork
            ar_issue(32'h200, 8'd1, 4'd3);
            wr_issue(32'h300, 8'd1, 4'd4, -1, 0);
        join
        wait_idle();

        oldv = model[8'h50];
        newv = $urandom;
        @(posedge aclk); #1;
        bus.araddr = 32'h140; bus.arlen = 8'd0; bus.arid = 4'd9; bus.arvalid = 1'b1;
        bus.awaddr = 32'h140; bus.awlen = 8'd0; bus.awid = 4'd10; bus.awvalid = 1'b1;
        @(negedge aclk);
        chk("coll_arready", 32'(bus.arready), 32'd1);
        chk("coll_awready", 32'(bus.awready), 32'd1);
        begin
            rbeat_t e;
            e.id = 4'd9; e.data = oldv; e.last = 1'b1;
            rd_q.push_back(e);
        end
        @(posedge aclk); #1;
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        bus.wdata = newv; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        @(negedge aclk);
        chk("coll_wready", 32'(bus.wready), 32'd1);
        chk("coll_rvalid_same_cycle", 32'(bus.rvalid), 32'd1);
        model[8'h50] = newv;
        b_q.push_back(4'd10);
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
        wait_idle();
        ar_issue(32'h140, 8'd0, 4'd11);
        wait_idle();

        ar_issue(32'hABC0_03F9, 8'd3, 4'd6);
        wait_idle();

        rready_mode = 2;
        bready_mode = 1;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 2);
            wl = 8'($urandom_range(0, 7));
            rl = 8'($urandom_range(0, 7));
            if (op == 0) begin
                fill(int'(wl) + 1, 1);
                wr_issue(mk_addr($urandom_range(0, NW - 1)), wl, 4'($urandom), -1, 2);
            end else if (op == 1) begin
                ar_issue(mk_addr($urandom_range(0, NW - 1)), rl, 4'($urandom));
            end else begin
                wb = $urandom_range(0, 120);
                rb = $urandom_range(128, 248);
                if ($urandom_range(0, 1) == 1) begin
                    op = wb; wb = rb; rb = op;
                end
                fill(int'(wl) + 1, 1);
                fork
                    ar_issue(mk_addr(rb), rl, 4'($urandom));
                    wr_issue(mk_addr(wb), wl, 4'($urandom), -1, 2);
                join
            end
            wait_idle();
        end
        rready_mode = 0;
        bready_mode = 0;

        fill(4, 0);
        wr_issue(32'h200, 8'd3, 4'd7, 2, 0);
        reset = 1'b1;
        @(negedge aclk);
        chk("rst_mid_wready", 32'(bus.wready), 32'd0);
        chk("rst_mid_bvalid0", 32'(bus.bvalid), 32'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("rst_mid_bvalid1", 32'(bus.bvalid), 32'd0);
        @(posedge aclk); #1;
        reset = 1'b0;
        @(negedge aclk);
        chk("rst_mid_awready", 32'(bus.awready), 32'd1);
        chk("rst_mid_arready", 32'(bus.arready), 32'd1);
        chk("rst_mid_bvalid2", 32'(bus.bvalid), 32'd0);
        ar_issue(32'h200, 8'd3, 4'd8);
        wait_idle();

        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("b_q_drained", 32'(b_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
